// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding and the instruction word size.
package imem_prog_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_CHECK = 3'd2,
    LD_RUN   = 3'd3,
    LD_ERROR = 3'd4
  } ld_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/imem_write_stage.sv
// Registered instruction-memory write port: turns an accepted program beat into
// a one-cycle im_we pulse and holds address/data between writes.
module imem_write_stage
  import imem_prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W:0]   wr_idx,
  input  logic [31:0]      wr_data,
  output logic             im_we,
  output logic [31:0]      im_waddr,
  output logic [31:0]      im_wdata
);

  logic [31:0] wr_addr;

  // Byte address wraps modulo 2^32 by the natural 32-bit width.
  assign wr_addr = BASE_ADDR + (32'(wr_idx) * WORD_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_we    <= 1'b0;
      im_waddr <= 32'd0;
      im_wdata <= 32'd0;
    end else begin
      im_we <= wr_en;
      if (wr_en) begin
        im_waddr <= wr_addr;
        im_wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/imem_prog_loader.sv
// Program loader: streams an image into instruction memory with the core held,
// checks the XOR checksum trailer, then releases the core via core_run.
module imem_prog_loader
  import imem_prog_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_waddr,
  output logic [31:0]      im_wdata,
  output logic             core_run,
  output logic             load_done,
  output logic             load_err,
  output logic [IDX_W:0]   word_count
);

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DEPTH_WORDS - 1);

  ld_state_e       state, state_nxt;
  logic [IDX_W:0]  idx;
  logic [31:0]     csum;
  logic            accept;
  logic            load_accept;
  logic            restart;

  assign in_ready    = (state == LD_LOAD) || (state == LD_CHECK);
  assign accept      = in_valid && in_ready;
  assign load_accept = accept && (state == LD_LOAD);
  assign restart     = (state_nxt == LD_LOAD) && (state != LD_LOAD);
  assign word_count  = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  // load_start is only honoured outside LOAD/CHECK; in_last wins over overflow.
  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (load_start) state_nxt = LD_LOAD;
      LD_LOAD: begin
        if (accept) begin
          if (in_last)              state_nxt = LD_CHECK;
          else if (idx == LAST_IDX) state_nxt = LD_ERROR;
        end
      end
      LD_CHECK: if (accept) state_nxt = (in_data == csum) ? LD_RUN : LD_ERROR;
      LD_RUN,
      LD_ERROR: if (load_start) state_nxt = LD_LOAD;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      csum      <= 32'd0;
      core_run  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      core_run  <= (state_nxt == LD_RUN);
      load_done <= (state_nxt == LD_RUN);
      load_err  <= (state_nxt == LD_ERROR);
      if ((state == LD_IDLE) || restart) begin
        idx  <= '0;
        csum <= 32'd0;
      end else if (load_accept) begin
        idx  <= idx + 1'b1;
        csum <= csum ^ in_data;
      end
    end
  end

  imem_write_stage #(
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_write_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (load_accept),
    .wr_idx   (idx),
    .wr_data  (in_data),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata)
  );

endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: scenario tasks with randomized
// images checked against an XOR/address reference model.
module tb_imem_prog_loader;

  localparam int          DEPTH = 256;
  localparam int          IW    = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          im_we;
  logic [31:0]   im_waddr;
  logic [31:0]   im_wdata;
  logic          core_run;
  logic          load_done;
  logic          load_err;
  logic [IW:0]   word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] img[$];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  imem_prog_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .IDX_W       (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .core_run   (core_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && im_we) begin
      wq_a.push_back(im_waddr);
      wq_d.push_back(im_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) until it is accepted.
  task automatic send_beat(input logic [31:0] d, input logic l, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (n < 50) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Loads img from the current state; good selects a correct or corrupted trailer.
  task automatic run_image(input bit good, input bit throttle);
    logic [31:0] model_csum;
    logic [31:0] trailer;
    logic [31:0] exp_addr;
    bit ok;
    int n;
    n = img.size();
    model_csum = 32'd0;
    foreach (img[i]) model_csum ^= img[i];
    trailer = good ? model_csum : (model_csum ^ (32'h1 << $urandom_range(31, 0)));

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b want 1", in_ready); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL start_core_run: got %b want 0", core_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL start_err_clear: got %b want 0", load_err); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL start_count: got %0d want 0", word_count); end
    wq_a.delete();
    wq_d.delete();

    for (int i = 0; i < n; i++) begin
      if (throttle) begin
        repeat ($urandom_range(2, 0)) begin
          tick();
          checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b want 0", im_we); end
        end
      end
      load_start = 1'($urandom_range(1, 0));
      send_beat(img[i], (i == n - 1), ok);
      load_start = 1'b0;
      exp_addr = BASE + 32'(i) * 32'd4;
      checks++; if (!ok) begin errors++; $display("FAIL beat_timeout: beat %0d not accepted", i); end
      checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL write_pulse: beat %0d got %b want 1", i, im_we); end
      checks++; if (im_waddr !== exp_addr) begin errors++; $display("FAIL write_addr: got %h want %h", im_waddr, exp_addr); end
      checks++; if (im_wdata !== img[i]) begin errors++; $display("FAIL write_data: got %h want %h", im_wdata, img[i]); end
      checks++; if (word_count !== (IW+1)'(i + 1)) begin errors++; $display("FAIL word_count: got %0d want %0d", word_count, i + 1); end
    end

    load_start = 1'($urandom_range(1, 0));
    send_beat(trailer, 1'($urandom_range(1, 0)), ok);
    load_start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL trailer_timeout: trailer not accepted"); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL trailer_write: got %b want 0", im_we); end
    checks++; if (core_run !== good) begin errors++; $display("FAIL core_run: got %b want %b", core_run, good); end
    checks++; if (load_done !== good) begin errors++; $display("FAIL load_done: got %b want %b", load_done, good); end
    checks++; if (load_err !== !good) begin errors++; $display("FAIL load_err: got %b want %b", load_err, !good); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL end_ready: got %b want 0", in_ready); end
    checks++; if (word_count !== (IW+1)'(n)) begin errors++; $display("FAIL final_count: got %0d want %0d", word_count, n); end
    checks++; if (wq_a.size() != n) begin errors++; $display("FAIL write_total: got %0d want %0d", wq_a.size(), n); end
    tick();
    tick();
    checks++; if (core_run !== good) begin errors++; $display("FAIL core_run_hold: got %b want %b", core_run, good); end
    checks++; if (load_err !== !good) begin errors++; $display("FAIL err_sticky: got %b want %b", load_err, !good); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", im_we); end
    checks++; if ({im_waddr, im_wdata} !== 64'd0) begin errors++; $display("FAIL rst_addr_data: got %h/%h want 0", im_waddr, im_wdata); end
    checks++; if ({core_run, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {core_run, load_done, load_err}); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", word_count); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_basic();
    img = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
    run_image(1'b1, 1'b0);
  endtask

  task automatic test_bad_checksum();
    img = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
    run_image(1'b0, 1'b0);
    run_image(1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] w;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      send_beat(w, 1'b0, ok);
      checks++; if (!ok || im_we !== 1'b1 || im_waddr !== BASE + 32'(i) * 32'd4 || im_wdata !== w) begin
        errors++; $display("FAIL ovf_write: beat %0d ok=%b we=%b addr=%h data=%h want addr=%h data=%h", i, ok, im_we, im_waddr, im_wdata, BASE + 32'(i) * 32'd4, w);
      end
    end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", load_err); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL ovf_core_run: got %b want 0", core_run); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", in_ready); end
    checks++; if (word_count !== (IW+1)'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", word_count, DEPTH); end
    in_valid = 1'b1;
    in_data = $urandom;
    repeat (3) begin
      tick();
      checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL ovf_no_write: got %b want 0", im_we); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_image();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run_image(1'b1, 1'b0);
  endtask

  task automatic test_throttle();
    for (int k = 0; k < 6; k++) begin
      img.delete();
      repeat ($urandom_range(12, 1)) img.push_back($urandom);
      run_image(1'($urandom_range(1, 0)), 1'b1);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_beat(32'h1111_1111, 1'b0, ok);
    send_beat(32'h2222_2222, 1'b0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, im_we, core_run, load_done, load_err} !== 5'b0) begin
      errors++; $display("FAIL async_rst_ctrl: got %b want 00000", {in_ready, im_we, core_run, load_done, load_err});
    end
    checks++; if ({im_waddr, im_wdata} !== 64'd0 || word_count !== '0) begin
      errors++; $display("FAIL async_rst_data: got %h/%h/%0d want 0", im_waddr, im_wdata, word_count);
    end
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b want 0", in_ready); end
    img = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
    run_image(1'b1, 1'b0);
  endtask

  task automatic test_reload_from_run();
    img = '{32'hDEAD_BEEF};
    run_image(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_overflow();
    test_full_image();
    test_throttle();
    test_async_reset();
    test_reload_from_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
